// File: rtl/display_timing_gen.sv
// Raster timing generator: signed pixel/line counters with registered sync,
// data-enable and line/frame strobes aligned to the coordinate outputs.
module display_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               i_ce,
  output logic signed [15:0] o_x,
  output logic signed [15:0] o_y,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic               o_line,
  output logic               o_frame,
  output logic [11:0]        H_RES,
  output logic [11:0]        V_RES
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_ACTIVE > 4095 || V_ACTIVE > 4095) begin : g_param_check
    $error("display_timing_gen: timing parameter out of range");
  end

  localparam int H_STA_I = -(H_FP + H_SYNC + H_BP);
  localparam int V_STA_I = -(V_FP + V_SYNC + V_BP);

  localparam logic signed [15:0] H_STA  = 16'(H_STA_I);
  localparam logic signed [15:0] V_STA  = 16'(V_STA_I);
  localparam logic signed [15:0] H_END  = 16'(H_ACTIVE - 1);
  localparam logic signed [15:0] V_END  = 16'(V_ACTIVE - 1);
  localparam logic signed [15:0] HS_BEG = 16'(H_STA_I + H_FP);
  localparam logic signed [15:0] HS_FIN = 16'(H_STA_I + H_FP + H_SYNC - 1);
  localparam logic signed [15:0] VS_BEG = 16'(V_STA_I + V_FP);
  localparam logic signed [15:0] VS_FIN = 16'(V_STA_I + V_FP + V_SYNC - 1);

  logic signed [15:0] x_q, x_d, y_q, y_d;
  logic run_q, run_d;
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, line_q, line_d, frame_q, frame_d;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    run_d   = run_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    de_d    = de_q;
    line_d  = line_q;
    frame_d = frame_q;
    if (i_ce) begin
      // First enabled edge after reset only primes the strobes at (H_STA,V_STA).
      run_d = 1'b1;
      if (run_q) begin
        if (x_q == H_END) begin
          x_d = H_STA;
          y_d = (y_q == V_END) ? V_STA : y_q + 16'sd1;
        end else begin
          x_d = x_q + 16'sd1;
        end
      end
      hs_d    = (x_d >= HS_BEG && x_d <= HS_FIN) ? HS_POL : !HS_POL;
      vs_d    = (y_d >= VS_BEG && y_d <= VS_FIN) ? VS_POL : !VS_POL;
      de_d    = !x_d[15] && !y_d[15];
      line_d  = (x_d == H_STA);
      frame_d = (x_d == H_STA) && (y_d == V_STA);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      x_q     <= H_STA;
      y_q     <= V_STA;
      run_q   <= 1'b0;
      hs_q    <= !HS_POL;
      vs_q    <= !VS_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      run_q   <= run_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_hs    = hs_q;
  assign o_vs    = vs_q;
  assign o_de    = de_q;
  assign o_line  = line_q;
  assign o_frame = frame_q;
  assign H_RES   = 12'(H_ACTIVE);
  assign V_RES   = 12'(V_ACTIVE);

endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
- Raster timing generator that drives the signed pixel-coordinate interface consumed by the scene renderers (i_x, i_y, H_RES, V_RES).
- Produces registered sync, data-enable and frame/line strobes aligned with the coordinate outputs.
- Sits between the pixel-clock domain and the renderer: coordinates → renderer; o_hs/o_vs/o_de plus renderer RGB → video output stage.
- Coordinates are negative during blanking and start at 0 for the first active pixel and line.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of o_hs (0 = active-low)
- VS_POL, 0, active level of o_vs (0 = active-low)

Ports:
- CLK  in  1  pixel clock
- RST_N  in  1  synchronous active-low reset
- i_ce  in  1  pixel clock enable; counters advance only when high
- o_x  out  16 signed  current horizontal coordinate
- o_y  out  16 signed  current vertical coordinate
- o_hs  out  1  horizontal sync, polarity HS_POL
- o_vs  out  1  vertical sync, polarity VS_POL
- o_de  out  1  high when o_x>=0 and o_y>=0
- o_line  out  1  strobe, high while o_x==H_STA
- o_frame  out  1  strobe, high while o_x==H_STA and o_y==V_STA
- H_RES  out  12  constant H_ACTIVE
- V_RES  out  12  constant V_ACTIVE

Behaviour:
- Derived constants:
  - H_STA = -(H_FP+H_SYNC+H_BP); V_STA = -(V_FP+V_SYNC+V_BP).
  - H_END = H_ACTIVE-1; V_END = V_ACTIVE-1.
  - Defaults: H_STA=-160, V_STA=-45, 800 total clocks per line, 525 lines per frame.
- Reset:
  - Applies at any CLK edge with RST_N=0, including mid-frame, and overrides i_ce.
  - o_x=H_STA, o_y=V_STA, o_hs=!HS_POL, o_vs=!VS_POL, o_de=0, o_line=0, o_frame=0.
- First enabled edge after RST_N rises: the counters stay at (H_STA,V_STA) and the outputs settle to o_line=1, o_frame=1. Counters advance only from the next enabled edge onward.
- Counters, on an enabled edge (i_ce=1):
  - If o_x==H_END: o_x<=H_STA; o_y<=(o_y==V_END)?V_STA:o_y+1.
  - Otherwise: o_x<=o_x+1; o_y unchanged.
  - All arithmetic is 16-bit signed; no other wrap exists.
- i_ce=0: every register, counters and strobes included, holds its value. Consumers qualify o_line and o_frame with i_ce.
- Registered outputs, all computed from the next counter value so they align with o_x/o_y in the same cycle (zero relative latency):
  - o_hs active iff H_STA+H_FP <= x <= H_STA+H_FP+H_SYNC-1. Default: -144..-49.
  - o_vs active iff V_STA+V_FP <= y <= V_STA+V_FP+V_SYNC-1. Default: -35..-34. o_vs changes only at line start (x=H_STA).
  - o_de = (x>=0)&&(y>=0).
- o_line pulses exactly once per line and o_frame once per frame, each for one enabled cycle.
- H_RES and V_RES are combinational constants, unaffected by reset.
- Structure: no state machine beyond the two counters. Comparisons against parameter-derived signed constants.
- Elaboration-time checks: every parameter >=1; H_ACTIVE and V_ACTIVE <= 4095.

Test Plan:
- Reset, then i_ce=1 for one full frame (defaults):
  - o_de high on exactly 307200 cycles; o_line pulses 525 times; o_frame pulses once.
  - The next frame starts after 420000 cycles.
- Line timing (defaults):
  - o_hs low for x=-144..-49 (96 cycles) and high elsewhere.
  - o_de rises at x=0 and falls after x=639.
  - o_x sequence 639 → -160 → -159.
- Frame wrap (defaults):
  - At y=479, x=639 the next state is y=-45, x=-160 with o_frame=1.
  - o_vs low only on lines y=-35 and y=-34.
- Polarity and small-frame config (H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1, HS_POL=1, VS_POL=1):
  - Period 7×5=35 cycles.
  - o_hs high only at x=-2; o_vs high only on y=-2.
- i_ce toggled 1,0,0,1 repeatedly: outputs advance only on enabled edges; the frame takes exactly 2×420000 cycles at 50% duty.
- RST_N=0 for one cycle at x=100, y=200: the next cycle shows x=-160, y=-45, o_de=0, o_hs=1, o_vs=1, o_frame=0.
